// File: rtl/main_mem.sv
// main_mem: word-addressed 32-bit memory with single and burst (4/8/16) access.
// Latency: writes land on the accepting edge; read data appears one edge after capture.
// Backpressure: busy=1 during a burst, and new requests are ignored until it drops.
//
// Ports: clock, reset (sync, active-high), enable (global gate), addr/data_in/data_out
// (bit 0 = MSB), acc_size (00 single, 01/10/11 = burst 4/8/16), wren (1 write), busy.
module main_mem #(
    parameter logic [31:0] START_ADDRESS = 32'h8002_0000,
    parameter int          DEPTH_WORDS   = 262144
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [0:31] addr,
    input  logic [0:31] data_in,
    output logic [0:31] data_out,
    input  logic [1:0]  acc_size,
    input  logic        wren,
    output logic        busy
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WBURST, RBURST} state_t;

    state_t      state;
    logic [4:0]  cnt;        // index of the next beat within the burst
    logic [4:0]  len_m1;     // burst length minus one, latched at acceptance
    logic [30:0] base_idx;   // word index of beat 0; 31 bits so +15 never wraps

    // Read pipeline: one registered address stage, then data_out.
    logic          rd_vld;
    logic          rd_oor;
    logic [AW-1:0] rd_idx;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0] addr_off;
    logic [30:0] req_idx;
    logic [4:0]  req_len_m1;
    logic [30:0] beat_idx;
    logic        accept;
    logic        wr_en;
    logic        wr_ok;
    logic [30:0] wr_idx;
    logic        bypass;

    // Addresses below START_ADDRESS wrap to a huge offset, so one
    // upper-bound compare covers both ends of the range.
    function automatic logic in_range(input logic [30:0] idx);
        return idx < 31'(DEPTH_WORDS);
    endfunction

    always_comb begin
        addr_off = addr - START_ADDRESS;
        req_idx  = {1'b0, addr_off[31:2]};
        case (acc_size)
            2'b00:   req_len_m1 = 5'd0;
            2'b01:   req_len_m1 = 5'd3;
            2'b10:   req_len_m1 = 5'd7;
            default: req_len_m1 = 5'd15;
        endcase
        beat_idx = base_idx + {26'b0, cnt};
        accept   = !reset && enable && (state == IDLE);

        wr_en  = 1'b0;
        wr_idx = '0;
        if (accept && wren) begin
            wr_en  = 1'b1;
            wr_idx = req_idx;
        end else if (!reset && enable && (state == WBURST)) begin
            wr_en  = 1'b1;
            wr_idx = beat_idx;
        end
        wr_ok = wr_en && in_range(wr_idx);

        // Write-first: a read presented on the same edge as a write to the
        // same word returns the incoming data rather than the stale array value.
        bypass = wr_ok && !rd_oor && (wr_idx[AW-1:0] == rd_idx);
    end

    // Storage is never reset; out-of-range beats are simply not written.
    always_ff @(posedge clock) begin
        if (wr_ok) begin
            mem[wr_idx[AW-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            data_out <= '0;
            rd_vld   <= 1'b0;
            rd_oor   <= 1'b0;
            rd_idx   <= '0;
            cnt      <= '0;
            len_m1   <= '0;
            base_idx <= '0;
        end else if (!enable) begin
            // Abort everything in flight; data_out keeps its last value.
            state  <= IDLE;
            busy   <= 1'b0;
            rd_vld <= 1'b0;
        end else begin
            if (rd_vld) begin
                if (rd_oor) begin
                    data_out <= '0;
                end else if (bypass) begin
                    data_out <= data_in;
                end else begin
                    data_out <= mem[rd_idx];
                end
            end
            rd_vld <= 1'b0;

            case (state)
                IDLE: begin
                    if (!wren) begin
                        rd_vld <= 1'b1;
                        rd_oor <= !in_range(req_idx);
                        rd_idx <= req_idx[AW-1:0];
                    end
                    if (req_len_m1 != 5'd0) begin
                        base_idx <= req_idx;
                        len_m1   <= req_len_m1;
                        cnt      <= 5'd1;
                        busy     <= 1'b1;
                        state    <= wren ? WBURST : RBURST;
                    end
                end
                WBURST: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == len_m1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RBURST: begin
                    // Issue beats 1..L-1; the edge after the last issue
                    // presents the final word and releases busy.
                    if (cnt <= len_m1) begin
                        rd_vld <= 1'b1;
                        rd_oor <= !in_range(beat_idx);
                        rd_idx <= beat_idx[AW-1:0];
                        cnt    <= cnt + 5'd1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_main_mem.sv
module tb_main_mem;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [0:31] addr;
    logic [0:31] data_in;
    logic [0:31] data_out;
    logic [1:0]  acc_size;
    logic        wren;
    logic        busy;

    int total  = 0;
    int passed = 0;

    always #5 clock = ~clock;

    main_mem dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .acc_size (acc_size),
        .wren     (wren),
        .busy     (busy)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz, input logic we);
        addr     = a;
        data_in  = d;
        acc_size = sz;
        wren     = we;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] pat(input logic [31:0] base, input int k);
        return base * 32'(k + 1);
    endfunction

    // Mid-burst inputs are junk (wren=0, size 00) to show they are ignored.
    task automatic burst_write(input logic [31:0] a, input int len,
                               input logic [1:0] sz, input logic [31:0] base);
        for (int k = 0; k < len; k++) begin
            if (k == 0) drive(a, pat(base, k), sz, 1'b1);
            else        drive(32'h8002_0000, pat(base, k), 2'b00, 1'b0);
            tick();
            check($sformatf("bw%0d_busy%0d", len, k), {31'b0, busy}, 32'(k < len - 1));
        end
    endtask

    // Mid-burst inputs request a burst16 read; acceptance would hold busy high.
    task automatic burst_read(input logic [31:0] a, input int len,
                              input logic [1:0] sz, input logic [31:0] base);
        drive(a, 32'h0, sz, 1'b0);
        tick();
        check($sformatf("br%0d_busy_start", len), {31'b0, busy}, 32'd1);
        drive(32'h8002_0000, 32'h0, 2'b11, 1'b0);
        for (int k = 0; k < len; k++) begin
            tick();
            check($sformatf("br%0d_data%0d", len, k), data_out, pat(base, k));
            check($sformatf("br%0d_busy%0d", len, k), {31'b0, busy}, 32'(k < len - 1));
        end
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        drive(32'h0, 32'h0, 2'b00, 1'b0);
        tick();
        tick();
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_data", data_out, 32'h0);
        reset = 1'b0;

        // Single write then single read
        drive(32'h8002_0000, 32'h27BD_FFE8, 2'b00, 1'b1);
        tick();
        check("sw_busy", {31'b0, busy}, 32'd0);
        drive(32'h8002_0000, 32'h0, 2'b00, 1'b0);
        tick();
        check("sr_busy", {31'b0, busy}, 32'd0);
        drive(32'h8001_FFFC, 32'h0, 2'b00, 1'b0);
        tick();
        check("sr_data", data_out, 32'h27BD_FFE8);

        // Bursts
        burst_write(32'h8002_0004, 4, 2'b01, 32'h1111_1111);
        burst_read (32'h8002_0004, 4, 2'b01, 32'h1111_1111);
        burst_write(32'h8002_0014, 8, 2'b10, 32'h0101_0101);
        burst_read (32'h8002_0014, 8, 2'b10, 32'h0101_0101);
        burst_write(32'h8002_0034, 16, 2'b11, 32'h0010_0203);
        burst_read (32'h8002_0034, 16, 2'b11, 32'h0010_0203);

        // Back-to-back singles
        for (int i = 0; i < 4; i++) begin
            drive(32'h8002_0074 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 2'b00, 1'b1);
            tick();
            check($sformatf("b2b_wbusy%0d", i), {31'b0, busy}, 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            drive(32'h8002_0074 + 32'(4 * i), 32'h0, 2'b00, 1'b0);
            tick();
            if (i > 0) check($sformatf("b2b_rd%0d", i - 1), data_out, 32'hC0DE_0000 + 32'(i - 1));
        end
        drive(32'h8002_0000, 32'h0, 2'b00, 1'b0);
        tick();
        check("b2b_rd3", data_out, 32'hC0DE_0003);
        tick();
        check("b2b_rd_w0", data_out, 32'h27BD_FFE8);

        // Write-first: read captured, then written on the presenting edge
        drive(32'h8002_0074, 32'h0, 2'b00, 1'b0);
        tick();
        drive(32'h8002_0074, 32'h5A5A_5A5A, 2'b00, 1'b1);
        tick();
        check("wfirst_same_edge", data_out, 32'h5A5A_5A5A);
        drive(32'h8002_0074, 32'h0, 2'b00, 1'b0);
        tick();
        drive(32'h8002_0000, 32'h0, 2'b00, 1'b0);
        tick();
        check("wfirst_later", data_out, 32'h5A5A_5A5A);

        // Out of range below and above
        drive(32'h8001_FFFC, 32'h0, 2'b00, 1'b0);
        tick();
        drive(32'h8002_0000, 32'h0, 2'b00, 1'b0);
        tick();
        check("oor_low", data_out, 32'h0);
        tick();
        check("oor_low_next", data_out, 32'h27BD_FFE8);
        drive(32'h8012_0000, 32'hDEAD_BEEF, 2'b00, 1'b1);
        tick();
        drive(32'h8012_0000, 32'h0, 2'b00, 1'b0);
        tick();
        drive(32'h8002_0000, 32'h0, 2'b00, 1'b0);
        tick();
        check("oor_high", data_out, 32'h0);
        tick();
        check("oor_high_noalias", data_out, 32'h27BD_FFE8);

        // Reset in the middle of a burst8 read
        drive(32'h8002_0014, 32'h0, 2'b10, 1'b0);
        tick();
        check("rstb_busy", {31'b0, busy}, 32'd1);
        drive(32'h8002_0000, 32'h0, 2'b11, 1'b0);
        tick();
        check("rstb_d0", data_out, pat(32'h0101_0101, 0));
        tick();
        check("rstb_d1", data_out, pat(32'h0101_0101, 1));
        reset = 1'b1;
        tick();
        check("rstb_busy_after", {31'b0, busy}, 32'd0);
        check("rstb_data_after", data_out, 32'h0);
        reset  = 1'b0;
        enable = 1'b0;
        tick();
        check("rstb_en0_data", data_out, 32'h0);
        check("rstb_en0_busy", {31'b0, busy}, 32'd0);
        enable = 1'b1;
        drive(32'h8002_0018, 32'h0, 2'b00, 1'b0);
        tick();
        drive(32'h8002_0000, 32'h0, 2'b00, 1'b0);
        tick();
        check("rstb_mem_kept", data_out, pat(32'h0101_0101, 1));
        tick();
        check("rstb_mem_kept_w0", data_out, 32'h27BD_FFE8);

        // enable=0 in the middle of a burst4 write
        drive(32'h8002_0108, 32'h0B0B_0B02, 2'b00, 1'b1);
        tick();
        drive(32'h8002_010C, 32'h0B0B_0B03, 2'b00, 1'b1);
        tick();
        drive(32'h8002_0100, 32'hE000_0000, 2'b01, 1'b1);
        tick();
        check("en_busy0", {31'b0, busy}, 32'd1);
        drive(32'h8002_0000, 32'hE000_0001, 2'b00, 1'b0);
        tick();
        check("en_busy1", {31'b0, busy}, 32'd1);
        enable = 1'b0;
        drive(32'h8002_0000, 32'hE000_0002, 2'b00, 1'b0);
        tick();
        check("en_abort_busy", {31'b0, busy}, 32'd0);
        check("en_hold_data", data_out, 32'h27BD_FFE8);
        enable = 1'b1;
        drive(32'h8002_0100, 32'hE000_0003, 2'b00, 1'b0);
        tick();
        check("en_idle_busy", {31'b0, busy}, 32'd0);
        drive(32'h8002_0104, 32'h0, 2'b00, 1'b0);
        tick();
        check("en_w0", data_out, 32'hE000_0000);
        drive(32'h8002_0108, 32'h0, 2'b00, 1'b0);
        tick();
        check("en_w1", data_out, 32'hE000_0001);
        drive(32'h8002_010C, 32'h0, 2'b00, 1'b0);
        tick();
        check("en_w2_dropped", data_out, 32'h0B0B_0B02);
        tick();
        check("en_w3_dropped", data_out, 32'h0B0B_0B03);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
